pattern_scan_ctrl: RTL and testbench

//  Sequencer for the serial pattern detector (pattern_fsm). Accepts a parallel

---
 rtl/pattern_scan_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pattern_scan_ctrl.sv
// Sequencer for one serial pattern detector: accepts a word, clears the detector,
// shifts the word out MSB-first and collects the detector's match pulses.
module pattern_scan_ctrl #(
    parameter int unsigned WORD_W  = 16,
    parameter int unsigned CNT_W   = 5,
    parameter int unsigned DET_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              det_rstn,
    output logic              det_data,
    input  logic              det_match,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [CNT_W-1:0]  first_pos,
    output logic              any_match
);

    localparam int unsigned SCAN_LEN = WORD_W + DET_LAT;
    localparam int unsigned SC_W     = $clog2(SCAN_LEN + 1);

    localparam logic [SC_W-1:0]  LAST_SHIFT   = SC_W'(WORD_W - 1);
    localparam logic [SC_W-1:0]  LAST_SCAN    = SC_W'(SCAN_LEN - 1);
    localparam logic [SC_W-1:0]  FIRST_SAMPLE = SC_W'(DET_LAT);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StShift,
        StDrain,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [SC_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic              det_data_q, det_data_d;
    logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0]  first_pos_q, first_pos_d;
    logic              any_match_q, any_match_d;

    logic              accept;
    logic              sample_en;
    logic [SC_W-1:0]   sample_idx;

    assign accept     = word_valid && (state_q == StIdle);
    // scan_cnt runs from the first SHIFT cycle through the end of DRAIN
    assign sample_en  = ((state_q == StShift) || (state_q == StDrain)) &&
                        (scan_cnt_q >= FIRST_SAMPLE);
    assign sample_idx = scan_cnt_q - FIRST_SAMPLE;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StClear;
            StClear: state_d = StShift;
            StShift: if (scan_cnt_q == LAST_SHIFT) state_d = StDrain;
            StDrain: if (scan_cnt_q == LAST_SCAN) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        word_ready = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        det_rstn   = 1'b0;
        unique case (state_q)
            StIdle: begin
                word_ready = 1'b1;
                busy       = 1'b0;
            end
            StClear: ;
            StShift: det_rstn = 1'b1;
            StDrain: det_rstn = 1'b1;
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state
    always_comb begin
        scan_cnt_d  = scan_cnt_q;
        shreg_d     = shreg_q;
        det_data_d  = 1'b0;
        match_cnt_d = match_cnt_q;
        first_pos_d = first_pos_q;
        any_match_d = any_match_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    shreg_d     = word_in;
                    match_cnt_d = '0;
                    first_pos_d = '0;
                    any_match_d = 1'b0;
                end
            end
            StClear: begin
                // det_data is registered, so the MSB is launched one cycle early
                scan_cnt_d = '0;
                det_data_d = shreg_q[WORD_W-1];
                shreg_d    = shreg_q << 1;
            end
            StShift: begin
                scan_cnt_d = scan_cnt_q + 1'b1;
                shreg_d    = shreg_q << 1;
                if (scan_cnt_q != LAST_SHIFT) begin
                    det_data_d = shreg_q[WORD_W-1];
                end
            end
            StDrain: scan_cnt_d = scan_cnt_q + 1'b1;
            StDone:  ;
            default: ;
        endcase

        if (sample_en && det_match) begin
            if (match_cnt_q != CNT_MAX) begin
                match_cnt_d = match_cnt_q + 1'b1;
            end
            if (!any_match_q) begin
                first_pos_d = CNT_W'(sample_idx);
                any_match_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_q  <= '0;
            shreg_q     <= '0;
            det_data_q  <= 1'b0;
            match_cnt_q <= '0;
            first_pos_q <= '0;
            any_match_q <= 1'b0;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            shreg_q     <= shreg_d;
            det_data_q  <= det_data_d;
            match_cnt_q <= match_cnt_d;
            first_pos_q <= first_pos_d;
            any_match_q <= any_match_d;
        end
    end

    assign det_data  = det_data_q;
    assign match_cnt = match_cnt_q;
    assign first_pos = first_pos_q;
    assign any_match = any_match_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Randomized bench for pattern_scan_ctrl: two instances (5-bit and 3-bit counters)
// each driving a stub detector, checked against a popcount/first-one model.
module tb_pattern_scan_ctrl;

    localparam int W     = 16;
    localparam int DL    = 1;
    localparam int TOTAL = W + DL + 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] word_in;
    logic         word_valid;

    logic       word_ready_a, det_rstn_a, det_data_a, det_match_a, busy_a, done_a, any_match_a;
    logic [4:0] match_cnt_a, first_pos_a;
    logic       word_ready_b, det_rstn_b, det_data_b, det_match_b, busy_b, done_b, any_match_b;
    logic [2:0] match_cnt_b, first_pos_b;

    logic pipe_a [DL];
    logic pipe_b [DL];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pattern_scan_ctrl #(.WORD_W(W), .CNT_W(5), .DET_LAT(DL)) dut_a (
        .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
        .word_ready(word_ready_a), .det_rstn(det_rstn_a), .det_data(det_data_a),
        .det_match(det_match_a), .busy(busy_a), .done(done_a),
        .match_cnt(match_cnt_a), .first_pos(first_pos_a), .any_match(any_match_a)
    );

    pattern_scan_ctrl #(.WORD_W(W), .CNT_W(3), .DET_LAT(DL)) dut_b (
        .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
        .word_ready(word_ready_b), .det_rstn(det_rstn_b), .det_data(det_data_b),
        .det_match(det_match_b), .busy(busy_b), .done(done_b),
        .match_cnt(match_cnt_b), .first_pos(first_pos_b), .any_match(any_match_b)
    );

    // Stub detector: det_data delayed by DL cycles, cleared while det_rstn is low
    always @(posedge clk) begin
        for (int i = DL - 1; i > 0; i--) begin
            pipe_a[i] <= det_rstn_a ? pipe_a[i-1] : 1'b0;
            pipe_b[i] <= det_rstn_b ? pipe_b[i-1] : 1'b0;
        end
        pipe_a[0] <= det_rstn_a ? det_data_a : 1'b0;
        pipe_b[0] <= det_rstn_b ? det_data_b : 1'b0;
    end
    assign det_match_a = pipe_a[DL-1];
    assign det_match_b = pipe_b[DL-1];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_ctl_a"}, 32'({word_ready_a, det_rstn_a, det_data_a, busy_a, done_a,
                                       any_match_a}), 32'h20);
        check_eq({tag, "_ctl_b"}, 32'({word_ready_b, det_rstn_b, det_data_b, busy_b, done_b,
                                       any_match_b}), 32'h20);
        check_eq({tag, "_res_a"}, 32'({match_cnt_a, first_pos_a}), 32'h0);
        check_eq({tag, "_res_b"}, 32'({match_cnt_b, first_pos_b}), 32'h0);
    endtask

    // Reference: count of ones, and index (0 = MSB) of the first one
    function automatic void model(input logic [W-1:0] w, output int pop, output int first);
        pop   = 0;
        first = -1;
        for (int k = 0; k < W; k++) begin
            if (w[W-1-k]) begin
                pop++;
                if (first < 0) first = k;
            end
        end
    endfunction

    // Scan one word. hold keeps word_valid high afterwards; abort_at > 0 pulses rst
    // in that cycle after accept (cycle 1 = CLEAR).
    task automatic run_word(input logic [W-1:0] w, input bit hold, input int abort_at);
        logic [W-1:0]     data_a, data_b;
        logic [TOTAL-1:0] rstn_seen, rstn_exp;
        bit               stray, not_busy;
        int               lat_a, lat_b, dc_a, dc_b, guard, pop, first;

        data_a = '0; data_b = '0; rstn_seen = '0; rstn_exp = '0;
        stray = 1'b0; not_busy = 1'b0;
        lat_a = 0; lat_b = 0; dc_a = 0; dc_b = 0; guard = 0;
        model(w, pop, first);

        word_in    = w;
        word_valid = 1'b1;
        while (!word_ready_a && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) begin
            check_eq("ready_timeout", 32'(guard), 32'd0);
            word_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (!hold) word_valid = 1'b0;
        word_in = W'($urandom);

        for (int c = 1; c <= TOTAL; c++) begin
            rstn_seen = {rstn_seen[TOTAL-2:0], det_rstn_a};
            rstn_exp  = {rstn_exp[TOTAL-2:0], 1'((c >= 2) && (c <= W + DL + 1))};
            if (c >= 2 && c <= W + 1) begin
                data_a = {data_a[W-2:0], det_data_a};
                data_b = {data_b[W-2:0], det_data_b};
            end else begin
                stray = stray | det_data_a | det_data_b;
            end
            if (done_a) begin dc_a++; lat_a = c; end
            if (done_b) begin dc_b++; lat_b = c; end
            not_busy = not_busy | !busy_a | !busy_b;
            if (c == abort_at) begin
                check_eq("abort_no_done", 32'(dc_a + dc_b), 32'd0);
                rst = 1'b1;
                #1;
                check_reset_vals("abort");
                rst        = 1'b0;
                word_valid = 1'b0;
                #1;
                return;
            end
            @(posedge clk); #1;
        end

        check_eq("latency_a", 32'(lat_a), 32'(TOTAL));
        check_eq("latency_b", 32'(lat_b), 32'(TOTAL));
        check_eq("done_pulses", 32'(dc_a * 4 + dc_b), 32'd5);
        check_eq("serial_a", 32'(data_a), 32'(w));
        check_eq("serial_b", 32'(data_b), 32'(w));
        check_eq("data_outside_shift", 32'(stray), 32'd0);
        check_eq("det_rstn_seq", 32'(rstn_seen), 32'(rstn_exp));
        check_eq("busy_in_scan", 32'(not_busy), 32'd0);
        // Now one cycle after DONE: idle, results held
        check_eq("idle_ctl", 32'({word_ready_a, busy_a, done_a, det_rstn_a}), 32'h8);
        check_eq("cnt_a", 32'(match_cnt_a), 32'((pop > 31) ? 31 : pop));
        check_eq("cnt_b", 32'(match_cnt_b), 32'((pop > 7) ? 7 : pop));
        check_eq("any_a", 32'(any_match_a), 32'(pop > 0));
        check_eq("any_b", 32'(any_match_b), 32'(pop > 0));
        check_eq("first_a", 32'(first_pos_a), 32'((first < 0) ? 0 : first));
        if (first < 8) check_eq("first_b", 32'(first_pos_b), 32'((first < 0) ? 0 : first));
    endtask

    initial begin
        rst        = 1'b1;
        word_valid = 1'b0;
        word_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        run_word(16'hA5A5, 1'b0, 0);
        run_word(16'h0001, 1'b0, 0);
        run_word(16'h0000, 1'b0, 0);
        run_word(16'hFFFF, 1'b0, 0);
        run_word(16'hA5A5, 1'b1, 7);
        run_word(16'h3C0F, 1'b0, 0);
        run_word(16'h1234, 1'b1, 0);
        run_word(16'hF00D, 1'b0, 0);
        for (int i = 0; i < 24; i++) begin
            run_word(W'($urandom), 1'($urandom_range(0, 1)), 0);
        end
        word_valid = 1'b0;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
